// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared memory sizing constants and requester ownership type
package rv32i_pkg;

  localparam int DATA_MEM_WORDS = 4096;
  localparam int MEM_ADDR_WIDTH = $clog2(DATA_MEM_WORDS);

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } mem_owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - bundle of requester and memory-side signals around mem_arbiter
interface mem_arbiter_if #(
  parameter int AW = 12,
  parameter int DW = 32
);
  localparam int BW = DW / 8;

  logic          ifu_req_i;
  logic [AW-1:0] ifu_addr_i;
  logic          ifu_flush_i;
  logic          ifu_gnt_o;
  logic          ifu_rvalid_o;
  logic [DW-1:0] ifu_rdata_o;

  logic          lsu_req_i;
  logic          lsu_we_i;
  logic [BW-1:0] lsu_be_i;
  logic [AW-1:0] lsu_addr_i;
  logic [DW-1:0] lsu_wdata_i;
  logic          lsu_gnt_o;
  logic          lsu_rvalid_o;
  logic [DW-1:0] lsu_rdata_o;

  logic          mem_gnt_i;
  logic [DW-1:0] mem_rdata_i;
  logic          mem_en_o;
  logic          mem_we_o;
  logic [BW-1:0] mem_be_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;

  // master: the requesters plus memory model; slave: the arbiter itself
  modport master (
    output ifu_req_i, ifu_addr_i, ifu_flush_i,
    output lsu_req_i, lsu_we_i, lsu_be_i, lsu_addr_i, lsu_wdata_i,
    output mem_gnt_i, mem_rdata_i,
    input  ifu_gnt_o, ifu_rvalid_o, ifu_rdata_o,
    input  lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o,
    input  mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );

  modport slave (
    input  ifu_req_i, ifu_addr_i, ifu_flush_i,
    input  lsu_req_i, lsu_we_i, lsu_be_i, lsu_addr_i, lsu_wdata_i,
    input  mem_gnt_i, mem_rdata_i,
    output ifu_gnt_o, ifu_rvalid_o, ifu_rdata_o,
    output lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o,
    output mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// rtl/mem_arbiter_rr_arb2.sv - combinational 2-way round-robin picker
module rr_arb2
  import rv32i_pkg::*;
(
  input  logic [1:0] req_i,   // bit 0 = IFU, bit 1 = LSU
  input  mem_owner_t last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      // on contention the side that did not win last time goes next
      2'b11:   gnt_o = (last_i == OWN_IFU) ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one single-port synchronous memory between fetch and load/store
module mem_arbiter
  import rv32i_pkg::*;
#(
  parameter int AW = MEM_ADDR_WIDTH,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            ifu_req_i,
  input  logic [AW-1:0]   ifu_addr_i,
  input  logic            ifu_flush_i,
  output logic            ifu_gnt_o,
  output logic            ifu_rvalid_o,
  output logic [DW-1:0]   ifu_rdata_o,

  input  logic            lsu_req_i,
  input  logic            lsu_we_i,
  input  logic [DW/8-1:0] lsu_be_i,
  input  logic [AW-1:0]   lsu_addr_i,
  input  logic [DW-1:0]   lsu_wdata_i,
  output logic            lsu_gnt_o,
  output logic            lsu_rvalid_o,
  output logic [DW-1:0]   lsu_rdata_o,

  input  logic            mem_gnt_i,
  input  logic [DW-1:0]   mem_rdata_i,
  output logic            mem_en_o,
  output logic            mem_we_o,
  output logic [DW/8-1:0] mem_be_o,
  output logic [AW-1:0]   mem_addr_o,
  output logic [DW-1:0]   mem_wdata_o
);

  mem_owner_t last_q, last_d;
  mem_owner_t own_q, own_d;
  logic       vld_q, vld_d;

  logic [1:0] req_v;
  logic [1:0] gnt;
  logic       accept;
  logic       resp_ifu;
  logic       resp_lsu;

  // a flushed fetch never competes, so LSU can still win that cycle
  assign req_v = {lsu_req_i, ifu_req_i & ~ifu_flush_i} & {2{mem_gnt_i & ~rst}};

  rr_arb2 u_rr_arb2 (
    .req_i  (req_v),
    .last_i (last_q),
    .gnt_o  (gnt)
  );

  assign ifu_gnt_o = gnt[0];
  assign lsu_gnt_o = gnt[1];
  assign accept    = |gnt;

  always_comb begin
    mem_en_o    = accept;
    mem_we_o    = 1'b0;
    mem_be_o    = '1;
    mem_addr_o  = ifu_addr_i;
    mem_wdata_o = '0;
    if (gnt[1]) begin
      mem_we_o    = lsu_we_i;
      mem_be_o    = lsu_be_i;
      mem_addr_o  = lsu_addr_i;
      mem_wdata_o = lsu_wdata_i;
    end
  end

  always_comb begin
    last_d = last_q;
    own_d  = own_q;
    vld_d  = accept;
    if (accept) begin
      last_d = gnt[1] ? OWN_LSU : OWN_IFU;
      own_d  = gnt[1] ? OWN_LSU : OWN_IFU;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= OWN_IFU;
      own_q  <= OWN_IFU;
      vld_q  <= 1'b0;
    end else begin
      last_q <= last_d;
      own_q  <= own_d;
      vld_q  <= vld_d;
    end
  end

  // a response landing in a reset cycle is dropped; flush only kills fetch responses
  assign resp_ifu = vld_q & ~rst & (own_q == OWN_IFU) & ~ifu_flush_i;
  assign resp_lsu = vld_q & ~rst & (own_q == OWN_LSU);

  assign ifu_rvalid_o = resp_ifu;
  assign lsu_rvalid_o = resp_lsu;
  assign ifu_rdata_o  = resp_ifu ? mem_rdata_i : '0;
  assign lsu_rdata_o  = resp_lsu ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a 1-cycle memory model
module tb_mem_arbiter;
  import rv32i_pkg::*;

  localparam int AW = 12;
  localparam int DW = 32;

  typedef struct {
    mem_owner_t  own;
    logic [31:0] data;
    int          cyc;
    logic        store;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;
  bit   mon_en;
  exp_t sb[$];

  logic [31:0] ref_mem [4096];
  logic [31:0] rd_q;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .ifu_req_i    (bus.ifu_req_i),
    .ifu_addr_i   (bus.ifu_addr_i),
    .ifu_flush_i  (bus.ifu_flush_i),
    .ifu_gnt_o    (bus.ifu_gnt_o),
    .ifu_rvalid_o (bus.ifu_rvalid_o),
    .ifu_rdata_o  (bus.ifu_rdata_o),
    .lsu_req_i    (bus.lsu_req_i),
    .lsu_we_i     (bus.lsu_we_i),
    .lsu_be_i     (bus.lsu_be_i),
    .lsu_addr_i   (bus.lsu_addr_i),
    .lsu_wdata_i  (bus.lsu_wdata_i),
    .lsu_gnt_o    (bus.lsu_gnt_o),
    .lsu_rvalid_o (bus.lsu_rvalid_o),
    .lsu_rdata_o  (bus.lsu_rdata_o),
    .mem_gnt_i    (bus.mem_gnt_i),
    .mem_rdata_i  (bus.mem_rdata_i),
    .mem_en_o     (bus.mem_en_o),
    .mem_we_o     (bus.mem_we_o),
    .mem_be_o     (bus.mem_be_o),
    .mem_addr_o   (bus.mem_addr_o),
    .mem_wdata_o  (bus.mem_wdata_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc = cyc + 1;

  // read-first memory: data of the accepted address shows up one cycle later
  always @(posedge clk) begin
    if (bus.mem_en_o) begin
      rd_q <= ref_mem[bus.mem_addr_o];
      if (bus.mem_we_o)
        for (int b = 0; b < 4; b++)
          if (bus.mem_be_o[b]) ref_mem[bus.mem_addr_o][8*b +: 8] <= bus.mem_wdata_o[8*b +: 8];
    end else begin
      rd_q <= 32'h5A5A_5A5A;
    end
  end
  assign bus.mem_rdata_i = rd_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // response monitor: pops the scoreboard whenever a response is due
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      bit   sup;
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        chk("stale_entry", 32'(e.cyc), 32'(cyc));
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e   = sb.pop_front();
        sup = rst || (e.own == OWN_IFU && bus.ifu_flush_i);
        if (sup) begin
          chk("sup_ifu_rvalid", 32'(bus.ifu_rvalid_o), 0);
          chk("sup_lsu_rvalid", 32'(bus.lsu_rvalid_o), 0);
        end else if (e.own == OWN_IFU) begin
          chk("ifu_rvalid", 32'(bus.ifu_rvalid_o), 1);
          chk("lsu_rvalid_idle", 32'(bus.lsu_rvalid_o), 0);
          chk("ifu_rdata", bus.ifu_rdata_o, e.data);
          chk("lsu_rdata_zero", bus.lsu_rdata_o, 0);
        end else begin
          chk("lsu_rvalid", 32'(bus.lsu_rvalid_o), 1);
          chk("ifu_rvalid_idle", 32'(bus.ifu_rvalid_o), 0);
          chk("ifu_rdata_zero", bus.ifu_rdata_o, 0);
          if (!e.store) chk("lsu_rdata", bus.lsu_rdata_o, e.data);
        end
      end else begin
        chk("no_ifu_rvalid", 32'(bus.ifu_rvalid_o), 0);
        chk("no_lsu_rvalid", 32'(bus.lsu_rvalid_o), 0);
        chk("ifu_rdata_idle", bus.ifu_rdata_o, 0);
        chk("lsu_rdata_idle", bus.lsu_rdata_o, 0);
      end
    end
  end

  task automatic step(input logic r, input logic mg, input logic ir, input logic [11:0] ia,
                      input logic fl, input logic lr, input logic lw, input logic [3:0] lb,
                      input logic [11:0] la, input logic [31:0] lwd, input logic [1:0] eg);
    exp_t e;
    @(posedge clk);
    #1;
    rst             = r;
    bus.mem_gnt_i   = mg;
    bus.ifu_req_i   = ir;
    bus.ifu_addr_i  = ia;
    bus.ifu_flush_i = fl;
    bus.lsu_req_i   = lr;
    bus.lsu_we_i    = lw;
    bus.lsu_be_i    = lb;
    bus.lsu_addr_i  = la;
    bus.lsu_wdata_i = lwd;
    @(negedge clk);
    chk("ifu_gnt", 32'(bus.ifu_gnt_o), 32'(eg[0]));
    chk("lsu_gnt", 32'(bus.lsu_gnt_o), 32'(eg[1]));
    chk("mem_en", 32'(bus.mem_en_o), 32'(eg[0] | eg[1]));
    if (eg[1]) begin
      chk("lsu_mem_we", 32'(bus.mem_we_o), 32'(lw));
      chk("lsu_mem_be", 32'(bus.mem_be_o), 32'(lb));
      chk("lsu_mem_addr", 32'(bus.mem_addr_o), 32'(la));
      if (lw) chk("lsu_mem_wdata", bus.mem_wdata_o, lwd);
      e.own = OWN_LSU; e.data = ref_mem[la]; e.cyc = cyc + 1; e.store = lw;
      sb.push_back(e);
    end else if (eg[0]) begin
      chk("ifu_mem_we", 32'(bus.mem_we_o), 0);
      chk("ifu_mem_be", 32'(bus.mem_be_o), 32'hF);
      chk("ifu_mem_addr", 32'(bus.mem_addr_o), 32'(ia));
      e.own = OWN_IFU; e.data = ref_mem[ia]; e.cyc = cyc + 1; e.store = 1'b0;
      sb.push_back(e);
    end else begin
      chk("idle_mem_we", 32'(bus.mem_we_o), 0);
    end
  endtask

  initial begin
    cyc = 0; checks = 0; failures = 0; mon_en = 0;
    rd_q = 32'h0;
    for (int a = 0; a < 4096; a++) ref_mem[a] = 32'hA500_0000 | 32'(a);
    rst = 1'b1;
    bus.mem_gnt_i = 0; bus.ifu_req_i = 0; bus.ifu_addr_i = 0; bus.ifu_flush_i = 0;
    bus.lsu_req_i = 0; bus.lsu_we_i = 0; bus.lsu_be_i = 0; bus.lsu_addr_i = 0; bus.lsu_wdata_i = 0;
    mon_en = 1;
    //   rst mg ir ia      fl lr lw be       la      wdata           gnt{lsu,ifu}
    step(1, 1, 1, 12'h010, 0, 1, 0, 4'hF, 12'h020, 32'h0,         2'b00);
    step(1, 1, 1, 12'h010, 0, 1, 0, 4'hF, 12'h020, 32'h0,         2'b00);
    step(0, 1, 1, 12'h010, 0, 1, 0, 4'hF, 12'h020, 32'h0,         2'b10);
    step(0, 1, 1, 12'h010, 0, 1, 0, 4'hF, 12'h021, 32'h0,         2'b01);
    for (int i = 0; i < 8; i++)
      step(0, 1, 1, 12'h100 + 12'(i), 0, 1, 0, 4'hF, 12'h200 + 12'(i), 32'h0,
           (i % 2 == 0) ? 2'b10 : 2'b01);
    step(0, 1, 0, 12'h000, 0, 1, 1, 4'b0011, 12'h005, 32'hDEADBEEF, 2'b10);
    step(0, 1, 0, 12'h000, 0, 0, 0, 4'hF, 12'h000, 32'h0,         2'b00);
    step(0, 1, 1, 12'h005, 0, 0, 0, 4'hF, 12'h000, 32'h0,         2'b01);
    for (int i = 0; i < 3; i++)
      step(0, 0, 1, 12'h011, 0, 1, 0, 4'hF, 12'h022, 32'h0,       2'b00);
    step(0, 1, 1, 12'h011, 0, 1, 0, 4'hF, 12'h022, 32'h0,         2'b10);
    step(0, 1, 0, 12'h000, 0, 1, 0, 4'hF, 12'h023, 32'h0,         2'b10);
    step(0, 1, 1, 12'h030, 0, 0, 0, 4'hF, 12'h000, 32'h0,         2'b01);
    step(0, 1, 1, 12'h031, 1, 1, 0, 4'hF, 12'h040, 32'h0,         2'b10);
    step(0, 1, 1, 12'h032, 1, 0, 0, 4'hF, 12'h000, 32'h0,         2'b00);
    step(0, 1, 0, 12'h000, 0, 1, 0, 4'hF, 12'h050, 32'h0,         2'b10);
    step(1, 1, 1, 12'h060, 0, 1, 0, 4'hF, 12'h070, 32'h0,         2'b00);
    step(0, 1, 1, 12'h060, 0, 1, 0, 4'hF, 12'h070, 32'h0,         2'b10);
    step(0, 1, 0, 12'h000, 0, 0, 0, 4'hF, 12'h000, 32'h0,         2'b00);
    step(0, 1, 0, 12'h000, 0, 0, 0, 4'hF, 12'h000, 32'h0,         2'b00);
    chk("store_merge", ref_mem[12'h005], 32'hA500_BEEF);
    chk("scoreboard_empty", 32'(sb.size()), 0);
    mon_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
